// File: rtl/game_link_pkg.sv
// rtl/game_link_pkg.sv - shared constants, FSM states and length helper for the game link serializer
package game_link_pkg;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'h55AA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_e;

  // Bytes before the checksum: sync(2) + player(2) + per wave (row byte + bitfield bytes)
  function automatic int payload_len(input int num_waves, input int wave_bits);
    return 4 + num_waves * (1 + wave_bits / 8);
  endfunction

endpackage

// File: rtl/game_packet_serializer_snapshot.sv
// rtl/game_packet_serializer_snapshot.sv - packet_snapshot_mux: latches the flattened packet and selects one byte by index
module packet_snapshot_mux
  import game_link_pkg::*;
#(
  parameter int          NUM_WAVES = 3,
  parameter int          WAVE_BITS = 40,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int          IDX_W     = $clog2(payload_len(NUM_WAVES, WAVE_BITS))
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_load,
  input  logic [7:0]                     i_player_x,
  input  logic [7:0]                     i_player_y,
  input  logic [NUM_WAVES*8-1:0]         i_wave_y,
  input  logic [NUM_WAVES*WAVE_BITS-1:0] i_wave_bitfield,
  input  logic [IDX_W-1:0]               i_index,
  output logic [7:0]                     o_byte
);

  localparam int PAYLOAD_LEN = payload_len(NUM_WAVES, WAVE_BITS);
  localparam int ROW_BYTES   = 1 + WAVE_BITS / 8;

  logic [PAYLOAD_LEN*8-1:0] w_flat;
  logic [PAYLOAD_LEN*8-1:0] r_snap;

  // Byte n of the packet lives at bits [8n+7:8n]; bitfields are already LSB-first contiguous
  always_comb begin
    w_flat         = '0;
    w_flat[15:0]   = SYNC_WORD;
    w_flat[23:16]  = i_player_x;
    w_flat[31:24]  = i_player_y;
    for (int k = 0; k < NUM_WAVES; k++) begin
      w_flat[8*(4+k*ROW_BYTES) +: 8]         = i_wave_y[8*k +: 8];
      w_flat[8*(5+k*ROW_BYTES) +: WAVE_BITS] = i_wave_bitfield[WAVE_BITS*k +: WAVE_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
    end else if (i_load) begin
      r_snap <= w_flat;
    end
  end

  always_comb begin
    o_byte = 8'h00;
    for (int i = 0; i < PAYLOAD_LEN; i++) begin
      if (i_index == IDX_W'(i)) o_byte = r_snap[8*i +: 8];
    end
  end

endmodule

// File: rtl/game_packet_serializer.sv
// rtl/game_packet_serializer.sv - snapshots game state on frame_tick and streams it as a checksummed byte packet
module game_packet_serializer
  import game_link_pkg::*;
#(
  parameter int          NUM_WAVES = 3,
  parameter int          WAVE_BITS = 40,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_tick,
  input  logic [7:0]                     player_x,
  input  logic [7:0]                     player_y,
  input  logic [NUM_WAVES*8-1:0]         wave_y,
  input  logic [NUM_WAVES*WAVE_BITS-1:0] wave_bitfield,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           tx_last,
  output logic                           busy,
  output logic [7:0]                     drop_count
);

  localparam int                PAYLOAD_LEN   = payload_len(NUM_WAVES, WAVE_BITS);
  localparam int                IDX_W         = $clog2(PAYLOAD_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [IDX_W-1:0]  FIRST_SUM_IDX = IDX_W'(2);

  state_e           r_state;
  state_e           w_next;
  logic [IDX_W-1:0] r_index;
  logic [7:0]       r_csum;
  logic [7:0]       r_drop;
  logic [7:0]       w_snap_byte;
  logic             w_load;
  logic             w_drop;

  // A tick is honoured when idle or exactly on the checksum handshake; anything else is dropped
  assign w_load     = frame_tick && ((r_state == IDLE) || ((r_state == CSUM) && tx_ready));
  assign w_drop     = frame_tick && !w_load;
  assign drop_count = r_drop;

  packet_snapshot_mux #(
    .NUM_WAVES (NUM_WAVES),
    .WAVE_BITS (WAVE_BITS),
    .SYNC_WORD (SYNC_WORD),
    .IDX_W     (IDX_W)
  ) u_snapshot (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_load          (w_load),
    .i_player_x      (player_x),
    .i_player_y      (player_y),
    .i_wave_y        (wave_y),
    .i_wave_bitfield (wave_bitfield),
    .i_index         (r_index),
    .o_byte          (w_snap_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    busy     = 1'b0;
    tx_data  = 8'h00;
    case (r_state)
      IDLE: begin
        if (frame_tick) w_next = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = w_snap_byte;
        if (tx_ready && (r_index == LAST_IDX)) w_next = CSUM;
      end
      CSUM: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_last  = 1'b1;
        tx_data  = r_csum;
        if (tx_ready) w_next = frame_tick ? SEND : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Sync bytes (index 0,1) are excluded from the running sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= '0;
      r_csum  <= 8'h00;
    end else if (w_load) begin
      r_index <= '0;
      r_csum  <= 8'h00;
    end else if ((r_state == SEND) && tx_ready) begin
      r_index <= r_index + 1'b1;
      if (r_index >= FIRST_SUM_IDX) r_csum <= r_csum + w_snap_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 8'h00;
    end else if (w_drop && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

endmodule

// File: tb/tb_game_packet_serializer.sv
// tb/tb_game_packet_serializer.sv - scoreboard bench for game_packet_serializer (default and minimal configurations)
module tb_game_packet_serializer;

  localparam int NW = 3;
  localparam int WB = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_tick = 1'b0;
  logic             tx_ready = 1'b1;
  logic [7:0]       player_x = 8'h00;
  logic [7:0]       player_y = 8'h00;
  logic [NW*8-1:0]  wave_y = '0;
  logic [NW*WB-1:0] wave_bitfield = '0;
  logic [7:0]       tx_data;
  logic [7:0]       drop_count;
  logic             tx_valid;
  logic             tx_last;
  logic             busy;

  logic       s_tick = 1'b0;
  logic       s_ready = 1'b1;
  logic [7:0] s_x = 8'hC3;
  logic [7:0] s_y = 8'h7E;
  logic [7:0] s_wy = 8'h91;
  logic [7:0] s_wb = 8'hB4;
  logic [7:0] s_data;
  logic [7:0] s_drop;
  logic       s_valid;
  logic       s_last;
  logic       s_busy;

  always #5 clk = ~clk;

  game_packet_serializer u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .player_x      (player_x),
    .player_y      (player_y),
    .wave_y        (wave_y),
    .wave_bitfield (wave_bitfield),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_last       (tx_last),
    .busy          (busy),
    .drop_count    (drop_count)
  );

  game_packet_serializer #(
    .NUM_WAVES (1),
    .WAVE_BITS (8)
  ) u_dut_small (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (s_tick),
    .player_x      (s_x),
    .player_y      (s_y),
    .wave_y        (s_wy),
    .wave_bitfield (s_wb),
    .tx_data       (s_data),
    .tx_valid      (s_valid),
    .tx_ready      (s_ready),
    .tx_last       (s_last),
    .busy          (s_busy),
    .drop_count    (s_drop)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  int         n_bytes = 0;
  int         n_last = 0;
  logic [8:0] exp_q[$];
  logic [8:0] s_q[$];
  logic       stall_pend = 1'b0;
  logic [9:0] stall_val = '0;
  logic [7:0] lit [22] = '{8'hAA, 8'h55, 8'h12, 8'h34, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                           8'h20, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h30, 8'h0B, 8'h0C, 8'h0D,
                           8'h0E, 8'h0F};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) check("stall_hold", {tx_valid, tx_last, tx_data}, stall_val);
      stall_pend = tx_valid && !tx_ready;
      stall_val  = {tx_valid, tx_last, tx_data};
      if (tx_valid && tx_ready) begin
        n_bytes++;
        if (tx_last) n_last++;
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("stream_byte", {tx_last, tx_data}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_valid && s_ready) begin
      check("small_byte_expected", s_q.size() != 0, 1);
      if (s_q.size() != 0) check("small_stream_byte", {s_last, s_data}, s_q.pop_front());
    end
  end

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push_literal();
    logic [7:0] cs = 8'h00;
    for (int i = 0; i < 22; i++) exp_q.push_back({1'b0, lit[i]});
    for (int i = 2; i < 22; i++) cs = cs + lit[i];
    exp_q.push_back({1'b1, cs});
  endtask

  task automatic push_model();
    logic [7:0] b[$];
    logic [7:0] cs = 8'h00;
    b.push_back(8'hAA);
    b.push_back(8'h55);
    b.push_back(player_x);
    b.push_back(player_y);
    for (int k = 0; k < NW; k++) begin
      b.push_back(wave_y[8*k +: 8]);
      for (int j = 0; j < WB / 8; j++) b.push_back(wave_bitfield[WB*k + 8*j +: 8]);
    end
    for (int i = 2; i < b.size(); i++) cs = cs + b[i];
    foreach (b[i]) exp_q.push_back({1'b0, b[i]});
    exp_q.push_back({1'b1, cs});
  endtask

  task automatic set_base_inputs();
    player_x      = 8'h12;
    player_y      = 8'h34;
    wave_y        = {8'h30, 8'h20, 8'h10};
    wave_bitfield = {40'h0F0E0D0C0B, 40'h0A09080706, 40'h0504030201};
  endtask

  task automatic start_packet(input bit use_model);
    frame_tick = 1'b1;
    if (use_model) push_model();
    else push_literal();
    tick_edge();
    frame_tick = 1'b0;
    check("first_valid", tx_valid, 1);
    check("first_byte", tx_data, 8'hAA);
  endtask

  task automatic drain(input bit rnd_ready, input bit scramble, input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (scramble) begin
        player_x      = 8'($urandom());
        player_y      = 8'($urandom());
        wave_y        = (NW*8)'($urandom());
        wave_bitfield = (NW*WB)'({$urandom(), $urandom(), $urandom(), $urandom()});
      end
      tick_edge();
      cyc++;
    end
    check("drain_in_time", exp_q.size() == 0, 1);
    tx_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick_edge();
    tick_edge();
    rst_n = 1'b1;
    tick_edge();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    int b0;
    int cyc;

    tick_edge();
    tick_edge();
    check("reset_valid", tx_valid, 0);
    check("reset_last", tx_last, 0);
    check("reset_busy", busy, 0);
    check("reset_data", tx_data, 0);
    check("reset_drop", drop_count, 0);
    rst_n = 1'b1;
    tick_edge();

    // Minimal configuration: 7-byte packet
    s_q.push_back({1'b0, 8'hAA});
    s_q.push_back({1'b0, 8'h55});
    s_q.push_back({1'b0, 8'hC3});
    s_q.push_back({1'b0, 8'h7E});
    s_q.push_back({1'b0, 8'h91});
    s_q.push_back({1'b0, 8'hB4});
    s_q.push_back({1'b1, 8'h86});
    s_tick = 1'b1;
    tick_edge();
    s_tick = 1'b0;
    cyc = 0;
    while (s_q.size() != 0 && cyc < 30) begin
      tick_edge();
      cyc++;
    end
    check("small_drain", s_q.size() == 0, 1);
    check("small_busy_after", s_busy, 0);
    check("small_drop", s_drop, 0);

    // Known default packet, ready held high
    set_base_inputs();
    start_packet(1'b0);
    drain(1'b0, 1'b0, 60);
    check("busy_after_pkt", busy, 0);
    check("valid_after_pkt", tx_valid, 0);

    // Pseudo-random backpressure
    start_packet(1'b1);
    drain(1'b1, 1'b0, 400);
    check("busy_after_rnd", busy, 0);

    // Inputs churn after the snapshot cycle
    start_packet(1'b1);
    drain(1'b0, 1'b1, 60);
    check("busy_after_scramble", busy, 0);

    // Five ticks mid-packet are dropped
    do_reset();
    set_base_inputs();
    l0 = n_last;
    start_packet(1'b1);
    for (int i = 0; i < 10; i++) begin
      frame_tick = (i % 2) == 0;
      tick_edge();
    end
    frame_tick = 1'b0;
    drain(1'b0, 1'b0, 60);
    repeat (5) tick_edge();
    check("drop_five", drop_count, 5);
    check("one_packet", n_last - l0, 1);
    check("idle_after_drops", busy, 0);

    // Drop counter saturation under stall
    do_reset();
    tx_ready = 1'b0;
    start_packet(1'b1);
    frame_tick = 1'b1;
    repeat (300) tick_edge();
    frame_tick = 1'b0;
    check("drop_saturate", drop_count, 255);
    check("stalled_byte", tx_data, 8'hAA);
    drain(1'b0, 1'b0, 60);

    // Back-to-back packet on the checksum handshake
    do_reset();
    start_packet(1'b1);
    cyc = 0;
    while (!tx_last && cyc < 40) begin
      tick_edge();
      cyc++;
    end
    check("csum_reached", tx_last, 1);
    player_x   = 8'hEE;
    player_y   = 8'hDD;
    frame_tick = 1'b1;
    push_model();
    tick_edge();
    frame_tick = 1'b0;
    check("b2b_valid", tx_valid, 1);
    check("b2b_byte", tx_data, 8'hAA);
    check("b2b_no_drop", drop_count, 0);
    drain(1'b0, 1'b0, 60);

    // Asynchronous reset at byte 7
    do_reset();
    set_base_inputs();
    start_packet(1'b1);
    frame_tick = 1'b1;
    tick_edge();
    frame_tick = 1'b0;
    repeat (6) tick_edge();
    check("byte7_before_reset", tx_data, 8'h03);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_last", tx_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", tx_data, 0);
    check("midrst_drop", drop_count, 0);
    exp_q.delete();
    tick_edge();
    rst_n = 1'b1;
    tick_edge();
    b0 = n_bytes;
    start_packet(1'b1);
    drain(1'b0, 1'b0, 60);
    check("full_len_after_rst", n_bytes - b0, 23);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
